// File: rtl/mdc_stream_pkg.sv
// Shared constants, types and helpers for the MDC stream port bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mdc_stream_pkg;

  // Output skid buffer holds at most this many tokens.
  localparam int SKID_DEPTH = 2;

  // Upper bound on the number of input channels.
  localparam int MAX_IN = 8;

  // Output skid buffer occupancy, in tokens.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  // Width needed to hold an occupancy of 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mdc_sync_fifo.sv
// Single-clock FIFO with registered occupancy, sticky overflow and synchronous flush.
// Latency: a write accepted at edge t is visible at the head (valid=1) after edge t; no fall-through.
// Backpressure: full is decoded from registered count, so a write is refused when full even if a read happens in the same cycle.
module mdc_sync_fifo
  import mdc_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int CW     = cnt_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr,
  output logic              full,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              valid,
  output logic [CW-1:0]     count,
  output logic              ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt_q;
  logic              ovf_q;
  logic              wr_ok;
  logic              rd_ok;

  assign full    = (cnt_q == FULL_CNT);
  assign valid   = (cnt_q != '0);
  assign count   = cnt_q;
  assign ovf     = ovf_q;
  assign rd_data = mem[rd_ptr];
  assign wr_ok   = wr & ~full;
  assign rd_ok   = rd & valid;

  // Pointers, occupancy and sticky overflow; flush wins over same-cycle traffic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      cnt_q <= cnt_q + CW'(wr_ok) - CW'(rd_ok);
      if (wr && full) ovf_q <= 1'b1;
    end
  end

  // Storage array; contents are don't-care after reset or flush.
  always_ff @(posedge clock) begin
    if (wr_ok && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mdc_stream_port_bank.sv
// N_IN buffered write/full inputs presented as valid/ready to the actor, actor output via a 2-entry skid buffer.
// Latency: 1 cycle input write to tvalid; 1 cycle actor push to out_wr (out_wr itself is combinational on out_full).
// Backpressure: in_full per channel from registered count; acc_out_tready drops when the skid buffer holds 2 tokens.
// Optional: define MDC_PORT_MONITOR_EN to add the in_tokens/out_tokens accepted-token counters.
module mdc_stream_port_bank
  import mdc_stream_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [N_IN*DATA_W-1:0]          in_data,
  input  logic [N_IN-1:0]                 in_wr,
  output logic [N_IN-1:0]                 in_full,
  output logic [N_IN-1:0]                 in_ovf,
  output logic [N_IN*cnt_w(DEPTH)-1:0]    in_count,
  output logic [N_IN*DATA_W-1:0]          acc_in_tdata,
  output logic [N_IN-1:0]                 acc_in_tvalid,
  input  logic [N_IN-1:0]                 acc_in_tready,
  input  logic [DATA_W-1:0]               acc_out_tdata,
  input  logic                            acc_out_tvalid,
  output logic                            acc_out_tready,
  output logic [DATA_W-1:0]               out_data,
  output logic                            out_wr,
  input  logic                            out_full
`ifdef MDC_PORT_MONITOR_EN
  ,
  output logic [N_IN*CNT_W-1:0]           in_tokens,
  output logic [CNT_W-1:0]                out_tokens
`endif
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [1:0] SKID_FULL = 2'(SKID_DEPTH);
  // An out-of-range configuration elaborates with no channels, which is obvious on first simulation.
  localparam int N_CH = (N_IN >= 1 && N_IN <= MAX_IN && CNT_W >= 1) ? N_IN : 0;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mdc_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CW     (CW)
    ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .flush   (flush),
      .wr_data (in_data[i*DATA_W +: DATA_W]),
      .wr      (in_wr[i]),
      .full    (in_full[i]),
      .rd      (acc_in_tready[i]),
      .rd_data (acc_in_tdata[i*DATA_W +: DATA_W]),
      .valid   (acc_in_tvalid[i]),
      .count   (in_count[i*CW +: CW]),
      .ovf     (in_ovf[i])
    );
  end

  skid_state_t       skid_q;
  skid_state_t       skid_d;
  logic [DATA_W-1:0] slot0;   // oldest token
  logic [DATA_W-1:0] slot1;
  logic              push;
  logic              pop;

  assign acc_out_tready = (skid_q < SKID_FULL);
  assign out_wr         = (skid_q != SKID_EMPTY) & ~out_full;
  assign out_data       = slot0;
  assign push           = acc_out_tvalid & acc_out_tready;
  assign pop            = out_wr;

  // Skid occupancy register; flush empties it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      skid_q <= SKID_EMPTY;
    else if (flush) skid_q <= SKID_EMPTY;
    else            skid_q <= skid_d;
  end

  // Next occupancy: push-only grows, pop-only shrinks, both together hold.
  always_comb begin
    skid_d = skid_q;
    case ({push, pop})
      2'b10:   skid_d = (skid_q == SKID_EMPTY) ? SKID_ONE : SKID_TWO;
      2'b01:   skid_d = (skid_q == SKID_TWO) ? SKID_ONE : SKID_EMPTY;
      default: skid_d = skid_q;
    endcase
  end

  // Skid data slots kept in FIFO order: a pop shifts slot1 down, a push fills the first free slot.
  always_ff @(posedge clock) begin
    if (!flush) begin
      if (pop) begin
        slot0 <= (push && skid_q == SKID_ONE) ? acc_out_tdata : slot1;
        if (push) slot1 <= acc_out_tdata;
      end else if (push) begin
        if (skid_q == SKID_EMPTY) slot0 <= acc_out_tdata;
        else                      slot1 <= acc_out_tdata;
      end
    end
  end

`ifdef MDC_PORT_MONITOR_EN
  for (genvar i = 0; i < N_CH; i++) begin : g_mon
    // Accepted-write counter per channel; wraps, cleared by reset only.
    always_ff @(posedge clock or posedge reset) begin
      if (reset)                       in_tokens[i*CNT_W +: CNT_W] <= '0;
      else if (in_wr[i] && !in_full[i] && !flush)
        in_tokens[i*CNT_W +: CNT_W] <= in_tokens[i*CNT_W +: CNT_W] + 1'b1;
    end
  end

  // Output pop counter; wraps, cleared by reset only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       out_tokens <= '0;
    else if (out_wr) out_tokens <= out_tokens + 1'b1;
  end
`else
  // Monitor counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mdc_stream_port_bank.sv
module tb_mdc_stream_port_bank;

  localparam int N_IN   = 2;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int CW     = 3;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     flush = 1'b0;
  logic [N_IN*DATA_W-1:0]   in_data = '0;
  logic [N_IN-1:0]          in_wr = '0;
  logic [N_IN-1:0]          in_full;
  logic [N_IN-1:0]          in_ovf;
  logic [N_IN*CW-1:0]       in_count;
  logic [N_IN*DATA_W-1:0]   acc_in_tdata;
  logic [N_IN-1:0]          acc_in_tvalid;
  logic [N_IN-1:0]          acc_in_tready = '0;
  logic [DATA_W-1:0]        acc_out_tdata = '0;
  logic                     acc_out_tvalid = 1'b0;
  logic                     acc_out_tready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_wr;
  logic                     out_full = 1'b0;
`ifdef MDC_PORT_MONITOR_EN
  logic [N_IN*CNT_W-1:0]    in_tokens;
  logic [CNT_W-1:0]         out_tokens;
`endif

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  logic [DATA_W-1:0] qo[$];

  mdc_stream_port_bank #(
    .N_IN(N_IN), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_data(in_data), .in_wr(in_wr), .in_full(in_full), .in_ovf(in_ovf),
    .in_count(in_count), .acc_in_tdata(acc_in_tdata), .acc_in_tvalid(acc_in_tvalid),
    .acc_in_tready(acc_in_tready), .acc_out_tdata(acc_out_tdata),
    .acc_out_tvalid(acc_out_tvalid), .acc_out_tready(acc_out_tready),
    .out_data(out_data), .out_wr(out_wr), .out_full(out_full)
`ifdef MDC_PORT_MONITOR_EN
    , .in_tokens(in_tokens), .out_tokens(out_tokens)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] exp_d;
    int idx;
    int popped;

    // Reset state
    #2;
    chk("rst_in_full", 64'(in_full), 0);
    chk("rst_in_ovf", 64'(in_ovf), 0);
    chk("rst_in_count", 64'(in_count), 0);
    chk("rst_tvalid", 64'(acc_in_tvalid), 0);
    chk("rst_out_tready", 64'(acc_out_tready), 1);
    chk("rst_out_wr", 64'(out_wr), 0);
    tick();
    reset = 1'b0;
    tick();

    // Ch0: four writes held by tready=0, then drained in order
    for (int i = 0; i < 4; i++) begin
      in_data[0 +: DATA_W] = 32'hA0 + 32'(i);
      in_wr[0] = 1'b1;
      q0.push_back(32'hA0 + 32'(i));
      tick();
    end
    in_wr = '0;
    settle();
    chk("ch0_count4", 64'(in_count[0 +: CW]), 4);
    chk("ch0_tvalid", 64'(acc_in_tvalid[0]), 1);
    chk("ch0_head", 64'(acc_in_tdata[0 +: DATA_W]), 64'h0A0);
    acc_in_tready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("ch0_drain_vld", 64'(acc_in_tvalid[0]), 1);
      exp_d = q0.pop_front();
      chk("ch0_drain_dat", 64'(acc_in_tdata[0 +: DATA_W]), 64'(exp_d));
      tick();
    end
    acc_in_tready[0] = 1'b0;
    settle();
    chk("ch0_empty", 64'(acc_in_tvalid[0]), 0);
    tick();

    // Ch1: five back-to-back writes into DEPTH=4, fifth overflows; then flush
    for (int i = 0; i < 5; i++) begin
      in_data[DATA_W +: DATA_W] = 32'hB0 + 32'(i);
      in_wr[1] = 1'b1;
      tick();
      if (i == 3) chk("ch1_full_after4", 64'(in_full[1]), 1);
    end
    in_wr = '0;
    settle();
    chk("ch1_ovf", 64'(in_ovf), 64'b10);
    chk("ch1_count", 64'(in_count[CW +: CW]), 4);
    chk("ch1_head_kept", 64'(acc_in_tdata[DATA_W +: DATA_W]), 64'h0B0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    chk("flush_count", 64'(in_count), 0);
    chk("flush_ovf", 64'(in_ovf), 0);
    chk("flush_full", 64'(in_full), 0);
    tick();

    // Ch1: write refused on full even with a same-cycle read, accepted next cycle
    for (int i = 0; i < 4; i++) begin
      in_data[DATA_W +: DATA_W] = 32'hC0 + 32'(i);
      in_wr[1] = 1'b1;
      q1.push_back(32'hC0 + 32'(i));
      tick();
    end
    in_data[DATA_W +: DATA_W] = 32'hC4;
    acc_in_tready[1] = 1'b1;
    tick();
    void'(q1.pop_front());
    settle();
    chk("full_rw_count", 64'(in_count[CW +: CW]), 3);
    chk("full_rw_ovf", 64'(in_ovf[1]), 1);
    acc_in_tready[1] = 1'b0;
    tick();
    q1.push_back(32'hC4);
    in_wr = '0;
    settle();
    chk("full_rw_next_count", 64'(in_count[CW +: CW]), 4);
    acc_in_tready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      exp_d = q1.pop_front();
      chk("ch1_drain_dat", 64'(acc_in_tdata[DATA_W +: DATA_W]), 64'(exp_d));
      tick();
    end
    acc_in_tready[1] = 1'b0;
    settle();
    chk("ch1_empty", 64'(acc_in_tvalid[1]), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Output: out_full held, skid fills after two pushes, then drains 1/cycle
    out_full = 1'b1;
    idx = 0;
    for (int i = 0; i < 2; i++) begin
      acc_out_tvalid = 1'b1;
      acc_out_tdata  = 32'h10 + 32'(idx);
      settle();
      chk("skid_tready_open", 64'(acc_out_tready), 1);
      qo.push_back(acc_out_tdata);
      idx++;
      tick();
    end
    acc_out_tdata = 32'h10 + 32'(idx);
    settle();
    chk("skid_tready_closed", 64'(acc_out_tready), 0);
    chk("skid_held_wr", 64'(out_wr), 0);
    out_full = 1'b0;
    popped = 0;
    for (int cyc = 0; cyc < 100 && popped < 16; cyc++) begin
      acc_out_tvalid = (idx < 16);
      acc_out_tdata  = 32'h10 + 32'(idx);
      settle();
      chk("out_wr_steady", 64'(out_wr), 1);
      if (out_wr) begin
        exp_d = (qo.size() > 0) ? qo.pop_front() : 32'hDEAD_BEEF;
        chk("out_data", 64'(out_data), 64'(exp_d));
        popped++;
      end
      if (acc_out_tvalid && acc_out_tready) begin
        qo.push_back(acc_out_tdata);
        idx++;
      end
      tick();
    end
    acc_out_tvalid = 1'b0;
    settle();
    chk("out_popped", 64'(popped), 16);
    chk("out_sb_empty", 64'(qo.size()), 0);
    chk("out_idle", 64'(out_wr), 0);
    tick();

    // Flush empties the skid buffer
    out_full = 1'b1;
    acc_out_tvalid = 1'b1;
    tick();
    tick();
    acc_out_tvalid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_full = 1'b0;
    settle();
    chk("flush_skid_tready", 64'(acc_out_tready), 1);
    chk("flush_skid_wr", 64'(out_wr), 0);
    tick();

    // Reset mid-burst: 3 input tokens queued and skid holding 2
    out_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[0 +: DATA_W] = 32'hD0 + 32'(i);
      in_wr[0] = 1'b1;
      acc_out_tvalid = (i < 2);
      acc_out_tdata  = 32'hE0 + 32'(i);
      tick();
    end
    in_wr = '0;
    acc_out_tvalid = 1'b0;
    settle();
    chk("pre_rst_count", 64'(in_count[0 +: CW]), 3);
    chk("pre_rst_tready", 64'(acc_out_tready), 0);
    reset = 1'b1;
    out_full = 1'b0;
    #1;
    chk("arst_tvalid", 64'(acc_in_tvalid), 0);
    chk("arst_count", 64'(in_count), 0);
    chk("arst_out_wr", 64'(out_wr), 0);
    chk("arst_tready", 64'(acc_out_tready), 1);
    chk("arst_full", 64'(in_full), 0);
    tick();
    reset = 1'b0;
    tick();

`ifdef MDC_PORT_MONITOR_EN
    // Monitor counters wrap modulo 2^CNT_W: 300 -> 44
    for (int c = 0; c < 300; c++) begin
      in_data[0 +: DATA_W] = 32'(c);
      in_wr[0] = 1'b1;
      acc_in_tready[0] = 1'b1;
      acc_out_tvalid = 1'b1;
      acc_out_tdata = 32'(c);
      tick();
    end
    in_wr = '0;
    acc_out_tvalid = 1'b0;
    tick();
    tick();
    tick();
    acc_in_tready = '0;
    settle();
    chk("mon_in_tokens0", 64'(in_tokens[0 +: CNT_W]), 44);
    chk("mon_in_tokens1", 64'(in_tokens[CNT_W +: CNT_W]), 0);
    chk("mon_out_tokens", 64'(out_tokens), 44);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mdc_stream_port_bank.md
# mdc_stream_port_bank

Parametrised port bank for a multi-dataflow accelerator network. It is the next generation of the fixed two-input, one-output FIFO wrapper. N_IN producer-side write/full channels are buffered in per-channel FIFOs and presented to the HLS actor as AXI-Stream-style valid/ready inputs. The actor's valid/ready output is registered through a 2-entry skid buffer onto the network's write/full output port. The block adds per-channel occupancy, a sticky overflow flag, and a synchronous flush.

## Interface
- N_IN, 2: number of input channels, 1..8.
- DATA_W, 32: token width in bits.
- DEPTH, 64: entries per input FIFO; power of two, ≥ 2.
- CNT_W, 32: monitor token-counter width.
- clock  in  1  sole clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous clear of FIFOs, skid buffer and sticky flags.
- in_data  in  N_IN*DATA_W  producer tokens; channel i is at bits [i*DATA_W +: DATA_W].
- in_wr  in  N_IN  producer write strobe per channel.
- in_full  out  N_IN  FIFO i holds DEPTH entries.
- in_ovf  out  N_IN  sticky: a write was attempted while full.
- in_count  out  N_IN*$clog2(DEPTH+1)  occupancy per channel.
- acc_in_tdata  out  N_IN*DATA_W  head of FIFO i.
- acc_in_tvalid  out  N_IN  FIFO i is non-empty.
- acc_in_tready  in  N_IN  actor consumes the head of FIFO i.
- acc_out_tdata  in  DATA_W  actor result.
- acc_out_tvalid  in  1  actor result valid.
- acc_out_tready  out  1  skid buffer can accept.
- out_data  out  DATA_W  network output token.
- out_wr  out  1  network output write strobe.
- out_full  in  1  downstream full.

## Operation
- Input write on channel i: accepted when in_wr[i] && !in_full[i].
  - An attempt while full is dropped, the FIFO is unchanged, and in_ovf[i] is set.
- Input read on channel i: occurs when acc_in_tvalid[i] && acc_in_tready[i]. acc_in_tready is ignored while tvalid is 0.
- Simultaneous write and read on a non-full, non-empty FIFO: count is unchanged, and both the data and pointers advance.
  - When the FIFO is full, the write is refused even if a read occurs in the same cycle, because in_full is decoded from registered count.
  - When the FIFO is empty, only the write takes effect; there is no fall-through.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count saturates logically at DEPTH, which the full check guarantees.
- Output path: skid occupancy occ ∈ {0,1,2}, in FIFO order.
  - acc_out_tready = (occ < 2).
  - Push occurs on acc_out_tvalid && acc_out_tready.
  - out_wr = (occ != 0) && !out_full, and out_data is the oldest entry. A pop happens when out_wr is 1.
  - Push and pop in the same cycle leave occ unchanged.
- flush is synchronous and overrides all same-cycle reads and writes. It zeroes counts, pointers, occ and in_ovf. Data RAM contents are don't-care.
- Reset values: in_full=0, in_ovf=0, in_count=0, acc_in_tvalid=0, acc_out_tready=1, out_wr=0, and monitor counters 0. acc_in_tdata and out_data are don't-care while their valid/wr is 0.
- Reset may be asserted mid-transfer. All in-flight tokens are discarded, and there is no partial write.

## Timing
- Input latency: a write accepted at edge t gives acc_in_tvalid=1 with that data after edge t.
- Each input channel sustains 1 token/cycle.
- Output latency: a push at edge t gives out_wr=1 after edge t when out_full=0. The output sustains 1 token/cycle.
- in_full, in_count, acc_in_tvalid and acc_out_tready are decoded from registers only.
- out_wr is combinational from occ and out_full. This is the only input-to-output combinational path.

## Configuration
- MDC_PORT_MONITOR_EN defined: adds ports in_tokens (out, N_IN*CNT_W) and out_tokens (out, CNT_W).
  - in_tokens counts accepted input writes per channel.
  - out_tokens counts out_wr pops.
  - Counters wrap modulo 2^CNT_W and are cleared by reset only, not by flush.
- MDC_PORT_MONITOR_EN undefined: neither the ports nor the counters exist. All other behaviour is identical.

## Structure
- Package mdc_stream_pkg holds:
  - the occupancy-width function cnt_w(DEPTH) = $clog2(DEPTH+1);
  - the skid depth constant SKID_DEPTH=2;
  - the N_IN bound constant MAX_IN=8.
- Sub-module mdc_sync_fifo (data, wr, full, rd, valid, count, ovf, flush) is instantiated N_IN times by a generate loop. The skid buffer is inline.

## Test plan
- Write 0xA0..0xA3 on ch0 with tready=0 → in_count[0]=4, tvalid[0]=1, tdata=0xA0. Then tready=1 for 4 cycles → 0xA0..0xA3 in order, and tvalid drops after the 4th.
- With DEPTH=4, write 5 tokens on ch1 back-to-back with tready=0 → in_full[1]=1 after the 4th, the 5th is dropped, and in_ovf[1]=1. Then flush → in_count=0 and in_ovf=0.
- Actor streams 0x10..0x1F with out_full held at 1 → acc_out_tready falls after 2 pushes. Releasing out_full → out_data 0x10..0x1F at 1/cycle with no loss or duplication.
- On a full FIFO, in_wr and tready asserted together → the write is refused and count goes DEPTH→DEPTH-1. On the next cycle the write is accepted.
- Assert reset mid-burst (3 tokens queued, occ=2) → all valid, wr and count outputs are 0 immediately (asynchronously), and acc_out_tready=1.
- With MDC_PORT_MONITOR_EN, 300 writes on ch0 and 300 pops with CNT_W=8 → in_tokens[0]=out_tokens=44 (wrap).
